ddr3_app_responder: RTL and testbench
=====================================

DDR3_APP_RESPONDER -- requirements
Module: ddr3_app_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 4; memory holds 2**ADDR_BITS burst lines of 576 bits.
REQ-002 SHALL have parameter INIT_CYCLES, default 64; cycles from reset release to phy_rdy.
REQ-003 SHALL have parameter RD_LATENCY, default 8; cycles from read acceptance to first read beat, legal range 2..255.
REQ-004 ddr3_clk  in  1  sole clock, all logic rising-edge.
REQ-005 ddr3_rst  in  1  asynchronous, active-high reset.
REQ-006 phy_rdy  out  1  calibration complete.
REQ-007 cal_fail  out  1  calibration failed, constant 0.
REQ-008 app_en  in  1  command valid.
REQ-009 app_cmd  in  3  3'b000 write, 3'b001 read.
REQ-010 app_addr  in  32  burst address; line index = app_addr[ADDR_BITS+2:3].
REQ-011 app_rdy  out  1  command accepted when app_en && app_rdy.
REQ-012 app_wdf_data  in  288  write beat.
REQ-013 app_wdf_mask  in  36  per-byte mask; bit n = 1 leaves byte n unwritten.
REQ-014 app_wdf_wren  in  1  write beat valid.
REQ-015 app_wdf_end  in  1  last beat of burst.
REQ-016 app_wdf_rdy  out  1  beat accepted when app_wdf_wren && app_wdf_rdy.
REQ-017 app_rd_data  out  288  read beat.
REQ-018 app_rd_data_valid  out  1  read beat valid.
REQ-019 app_rd_data_end  out  1  last read beat.

Function
REQ-020 Init counter SHALL assert phy_rdy exactly INIT_CYCLES cycles after ddr3_rst deasserts; phy_rdy SHALL then hold 1 until reset.
REQ-021 app_rdy and app_wdf_rdy SHALL be 0 while phy_rdy is 0.
REQ-022 SHALL hold at most one accepted command; app_rdy = phy_rdy && no command pending.
REQ-023 Write data buffer SHALL hold 2 beats, filling in order; app_wdf_rdy = phy_rdy && buffer not holding a complete burst; data may arrive before or after its command.
REQ-024 A burst is complete on the beat accepted with app_wdf_end=1; if end arrives on beat 0, beat 1 SHALL be treated as fully masked.
REQ-025 Write commit SHALL occur the cycle after both a pending write command and a complete burst exist: beat 0 into line[287:0], beat 1 into line[575:288], byte-masked; pending and buffer clear in that cycle.
REQ-026 Read accepted at cycle T SHALL produce beat 0 (line[287:0]) with valid=1, end=0 at T+RD_LATENCY and beat 1 (line[575:288]) with valid=1, end=1 at T+RD_LATENCY+1; pending clears after beat 1.
REQ-027 Read data SHALL reflect all writes committed before read acceptance.
REQ-028 Commands other than 000/001 SHALL be accepted and discarded, freeing app_rdy the next cycle.
REQ-029 Address bits outside app_addr[ADDR_BITS+2:3] SHALL be ignored (address wraps modulo depth).
REQ-030 app_rd_data SHALL be 0 whenever app_rd_data_valid is 0.

Reset
REQ-031 Reset SHALL clear init counter, phy_rdy, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, app_rd_data, pending command, write buffer and read pipeline, including mid-burst.
REQ-032 Memory array SHALL NOT be reset; contents survive ddr3_rst.

Configuration
REQ-033 With DDR3_RESP_BACKPRESSURE_EN defined, app_rdy and app_wdf_rdy SHALL additionally be gated low by independent bits of a 16-bit LFSR (seed 16'hACE1, advanced every cycle after phy_rdy), about 25% of cycles each.
REQ-034 Without DDR3_RESP_BACKPRESSURE_EN, REQ-022/REQ-023 apply unmodified and no LFSR exists.

Structure
REQ-035 Package ddr3_app_pkg SHALL hold CMD_WRITE, CMD_READ, beat width 288, mask width 36, line width 576.
REQ-036 Read latency pipeline SHALL be sub-module ddr3_rd_delay (RD_LATENCY-deep valid/data shift).

Verification
REQ-037 Reset release -> phy_rdy rises exactly at cycle 64; app_rdy=0 before.
REQ-038 Write addr 0x10, beats 0xAA..A/0x55..5, mask 0, then read 0x10 -> beat0 0xAA..A at T+8, beat1 0x55..5 with end=1 at T+9.
REQ-039 Write data sent 3 cycles before command, mask[0]=1 -> byte 0 retains old value on readback.
REQ-040 Read 0x10 and 0x10+(16<<3) -> identical data (wrap).
REQ-041 ddr3_rst asserted between write beats -> outputs cleared; after re-init, prior committed data still readable.
REQ-042 With DDR3_RESP_BACKPRESSURE_EN, 1000 random write/read pairs -> all readbacks match scoreboard, app_rdy observed low post-init.

Source files
------------

// File: rtl/ddr3_app_pkg.sv
// rtl/ddr3_app_pkg.sv - shared command codes, beat/line widths and byte-merge helper for the DDR3 app responder
package ddr3_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int BEAT_W = 288;
    localparam int MASK_W = 36;
    localparam int LINE_W = 576;

    // A set mask bit keeps the old byte.
    function automatic logic [BEAT_W-1:0] merge_beat(
        input logic [BEAT_W-1:0] old_beat,
        input logic [BEAT_W-1:0] new_beat,
        input logic [MASK_W-1:0] mask
    );
        logic [BEAT_W-1:0] r;
        for (int b = 0; b < MASK_W; b++) begin
            r[8*b +: 8] = mask[b] ? old_beat[8*b +: 8] : new_beat[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr3_rd_delay.sv
// rtl/ddr3_rd_delay.sv - fixed-depth valid/data shift that times read beats
module ddr3_rd_delay #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= {valid_q[DEPTH-2:0], valid_i};
            data_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/ddr3_app_responder.sv
// rtl/ddr3_app_responder.sv - DDR3 app-interface responder: init delay, one-command queue, 2-beat write buffer, fixed-latency reads
// Optional random ready gating enabled by DDR3_RESP_BACKPRESSURE_EN.
module ddr3_app_responder
    import ddr3_app_pkg::*;
#(
    parameter int ADDR_BITS   = 4,
    parameter int INIT_CYCLES = 64,
    parameter int RD_LATENCY  = 8
) (
    input  logic              ddr3_clk,
    input  logic              ddr3_rst,
    output logic              phy_rdy,
    output logic              cal_fail,
    input  logic              app_en,
    input  logic [2:0]        app_cmd,
    input  logic [31:0]       app_addr,
    output logic              app_rdy,
    input  logic [BEAT_W-1:0] app_wdf_data,
    input  logic [MASK_W-1:0] app_wdf_mask,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    output logic              app_wdf_rdy,
    output logic [BEAT_W-1:0] app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end
);

    localparam int DEPTH = 2**ADDR_BITS;
    localparam int CNT_W = $clog2(INIT_CYCLES + 1);

    logic [CNT_W-1:0]     init_cnt_q;
    logic                 phy_rdy_q;
    logic                 pend_q, pend_d;
    logic                 pend_rd_q, pend_rd_d;
    logic [ADDR_BITS-1:0] pend_line_q, pend_line_d;
    logic                 wbuf_cnt_q, wbuf_cnt_d;
    logic                 wbuf_full_q, wbuf_full_d;
    logic [BEAT_W-1:0]    wbuf_data_q [2];
    logic [MASK_W-1:0]    wbuf_mask_q [2];
    logic                 rd_beat1_q;
    logic [ADDR_BITS-1:0] rd_line_q;
    logic [LINE_W-1:0]    mem_q [DEPTH];

    logic                 cmd_gate, wdf_gate;
    logic                 cmd_acc, wdf_acc, cmd_is_wr, cmd_is_rd, commit;
    logic [ADDR_BITS-1:0] acc_line;
    logic                 dly_valid;
    logic [ADDR_BITS-1:0] dly_line;
    logic                 addr_unused;

    always_ff @(posedge ddr3_clk or posedge ddr3_rst) begin
        if (ddr3_rst) begin
            init_cnt_q <= '0;
            phy_rdy_q  <= 1'b0;
        end else if (!phy_rdy_q) begin
            if (init_cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                phy_rdy_q <= 1'b1;
            end else begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
        end
    end

`ifdef DDR3_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge ddr3_clk or posedge ddr3_rst) begin
        if (ddr3_rst) begin
            lfsr_q <= 16'hACE1;
        end else if (phy_rdy_q) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Two disjoint bit pairs, each all-zero one cycle in four.
    assign cmd_gate = (lfsr_q[1:0] != 2'b00);
    assign wdf_gate = (lfsr_q[9:8] != 2'b00);
`else
    assign cmd_gate = 1'b1;
    assign wdf_gate = 1'b1;
`endif

    assign app_rdy     = phy_rdy_q && !pend_q && cmd_gate;
    assign app_wdf_rdy = phy_rdy_q && !wbuf_full_q && wdf_gate;
    assign phy_rdy     = phy_rdy_q;
    assign cal_fail    = 1'b0;

    assign cmd_acc     = app_en && app_rdy;
    assign wdf_acc     = app_wdf_wren && app_wdf_rdy;
    assign cmd_is_wr   = (app_cmd == CMD_WRITE);
    assign cmd_is_rd   = (app_cmd == CMD_READ);
    assign acc_line    = app_addr[ADDR_BITS+2:3];
    assign commit      = pend_q && !pend_rd_q && wbuf_full_q;
    assign addr_unused = ^{app_addr[31:ADDR_BITS+3], app_addr[2:0]};

    always_comb begin
        pend_d      = pend_q;
        pend_rd_d   = pend_rd_q;
        pend_line_d = pend_line_q;
        wbuf_cnt_d  = wbuf_cnt_q;
        wbuf_full_d = wbuf_full_q;
        if (commit || rd_beat1_q) begin
            pend_d = 1'b0;
        end
        // Unknown opcodes are accepted but never occupy the command slot.
        if (cmd_acc && (cmd_is_wr || cmd_is_rd)) begin
            pend_d      = 1'b1;
            pend_rd_d   = cmd_is_rd;
            pend_line_d = acc_line;
        end
        if (commit) begin
            wbuf_cnt_d  = 1'b0;
            wbuf_full_d = 1'b0;
        end else if (wdf_acc) begin
            wbuf_full_d = app_wdf_end || wbuf_cnt_q;
            wbuf_cnt_d  = !(app_wdf_end || wbuf_cnt_q);
        end
    end

    always_ff @(posedge ddr3_clk or posedge ddr3_rst) begin
        if (ddr3_rst) begin
            pend_q      <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_line_q <= '0;
            wbuf_cnt_q  <= 1'b0;
            wbuf_full_q <= 1'b0;
            rd_beat1_q  <= 1'b0;
            rd_line_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                wbuf_data_q[i] <= '0;
                wbuf_mask_q[i] <= '0;
            end
        end else begin
            pend_q      <= pend_d;
            pend_rd_q   <= pend_rd_d;
            pend_line_q <= pend_line_d;
            wbuf_cnt_q  <= wbuf_cnt_d;
            wbuf_full_q <= wbuf_full_d;
            rd_beat1_q  <= dly_valid;
            rd_line_q   <= dly_line;
            if (wdf_acc) begin
                wbuf_data_q[wbuf_cnt_q] <= app_wdf_data;
                wbuf_mask_q[wbuf_cnt_q] <= app_wdf_mask;
                if (app_wdf_end && !wbuf_cnt_q) begin
                    wbuf_mask_q[1] <= '1;
                end
            end
        end
    end

    // Storage deliberately outside reset so contents survive ddr3_rst.
    always_ff @(posedge ddr3_clk) begin
        if (commit) begin
            mem_q[pend_line_q] <= {
                merge_beat(mem_q[pend_line_q][LINE_W-1:BEAT_W], wbuf_data_q[1], wbuf_mask_q[1]),
                merge_beat(mem_q[pend_line_q][BEAT_W-1:0],      wbuf_data_q[0], wbuf_mask_q[0])
            };
        end
    end

    ddr3_rd_delay #(
        .DEPTH  (RD_LATENCY),
        .DATA_W (ADDR_BITS)
    ) u_rd_delay (
        .clk_i   (ddr3_clk),
        .rst_i   (ddr3_rst),
        .valid_i (cmd_acc && cmd_is_rd),
        .data_i  (acc_line),
        .valid_o (dly_valid),
        .data_o  (dly_line)
    );

    always_comb begin
        app_rd_data = '0;
        if (dly_valid) begin
            app_rd_data = mem_q[dly_line][BEAT_W-1:0];
        end else if (rd_beat1_q) begin
            app_rd_data = mem_q[rd_line_q][LINE_W-1:BEAT_W];
        end
    end

    assign app_rd_data_valid = dly_valid || rd_beat1_q;
    assign app_rd_data_end   = rd_beat1_q;

endmodule

// File: tb/tb_ddr3_app_responder.sv
// tb/tb_ddr3_app_responder.sv - scoreboard bench for ddr3_app_responder with random traffic and a line-level memory model
module tb_ddr3_app_responder;

    localparam int L    = 8;
    localparam int INIT = 64;

    logic         ddr3_clk = 1'b0;
    logic         ddr3_rst = 1'b1;
    logic         phy_rdy, cal_fail, app_rdy, app_wdf_rdy;
    logic         app_rd_data_valid, app_rd_data_end;
    logic         app_en = 1'b0, app_wdf_wren = 1'b0, app_wdf_end = 1'b0;
    logic [2:0]   app_cmd = 3'b000;
    logic [31:0]  app_addr = 32'h0;
    logic [287:0] app_wdf_data = '0;
    logic [35:0]  app_wdf_mask = '0;
    logic [287:0] app_rd_data;

    typedef struct packed {
        logic [287:0] data;
        logic         last;
        int           at;
    } exp_t;

    exp_t         sb[$];
    logic [575:0] model [16];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           bp_low = 0;

    ddr3_app_responder #(.ADDR_BITS(4), .INIT_CYCLES(INIT), .RD_LATENCY(L)) dut (
        .ddr3_clk          (ddr3_clk),
        .ddr3_rst          (ddr3_rst),
        .phy_rdy           (phy_rdy),
        .cal_fail          (cal_fail),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_rdy           (app_rdy),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask      (app_wdf_mask),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data_end   (app_rd_data_end)
    );

    always #5 ddr3_clk = ~ddr3_clk;
    always @(posedge ddr3_clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge ddr3_clk) begin : monitor
        exp_t e;
        if (!ddr3_rst) begin
            if (phy_rdy && !app_rdy) bp_low++;
            if (app_rd_data_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got valid=1 want no beat at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", app_rd_data, e.data);
                    chk("rd_end", app_rd_data_end, e.last);
                    chk("rd_cycle", cyc, e.at);
                end
            end else begin
                chk("rd_idle_data", app_rd_data, '0);
                chk("rd_idle_end", app_rd_data_end, 1'b0);
            end
        end
    end

    function automatic logic [287:0] rnd288();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [35:0] rmask();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0, 1:    return '0;
            2:       return t[35:0];
            default: return '1;
        endcase
    endfunction

    task automatic issue_cmd(input logic [2:0] cmd, input logic [31:0] addr, output int acc_cyc);
        int n = 0;
        app_en = 1'b1; app_cmd = cmd; app_addr = addr;
        while (!app_rdy && n < 500) begin @(negedge ddr3_clk); n++; end
        if (!app_rdy) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: got app_rdy=0 want 1 within 500 cycles");
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
        end
        @(negedge ddr3_clk);
        app_en = 1'b0;
    endtask

    task automatic send_beat(input logic [287:0] d, input logic [35:0] m, input logic last);
        int n = 0;
        app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = last;
        while (!app_wdf_rdy && n < 500) begin @(negedge ddr3_clk); n++; end
        if (!app_wdf_rdy) begin
            checks++; errors++;
            $display("FAIL wdf_timeout: got app_wdf_rdy=0 want 1 within 500 cycles");
        end
        @(negedge ddr3_clk);
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    // mode 0: command first; 1: data 3 cycles before command; 2: command between beats
    task automatic do_write(input logic [31:0] addr, input logic [287:0] d0, input logic [287:0] d1,
                            input logic [35:0] m0, input logic [35:0] m1, input bit single, input int mode);
        int acc;
        logic [3:0] ln;
        ln = addr[6:3];
        for (int b = 0; b < 36; b++) begin
            if (!m0[b]) model[ln][8*b +: 8] = d0[8*b +: 8];
            if (!single && !m1[b]) model[ln][288 + 8*b +: 8] = d1[8*b +: 8];
        end
        if (mode == 0) begin
            issue_cmd(3'b000, addr, acc);
            send_beat(d0, m0, single);
            if (!single) send_beat(d1, m1, 1'b1);
        end else if (mode == 1) begin
            send_beat(d0, m0, single);
            if (!single) send_beat(d1, m1, 1'b1);
            repeat (3) @(negedge ddr3_clk);
            issue_cmd(3'b000, addr, acc);
        end else begin
            send_beat(d0, m0, single);
            issue_cmd(3'b000, addr, acc);
            if (!single) send_beat(d1, m1, 1'b1);
        end
    endtask

    task automatic do_read(input logic [31:0] addr);
        int acc;
        logic [3:0] ln;
        ln = addr[6:3];
        issue_cmd(3'b001, addr, acc);
        if (acc >= 0) begin
            sb.push_back('{data: model[ln][287:0],   last: 1'b0, at: acc + L});
            sb.push_back('{data: model[ln][575:288], last: 1'b1, at: acc + L + 1});
        end
    endtask

    task automatic wait_init();
        int k = 0;
        while (!phy_rdy && k < 200) begin @(negedge ddr3_clk); k++; end
        chk("init_cycles", k, INIT);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        int acc, n_pairs;
        logic [31:0] a;

        repeat (3) @(negedge ddr3_clk);
        chk("rst_phy_rdy", phy_rdy, 1'b0);
        chk("rst_app_rdy", app_rdy, 1'b0);
        chk("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        chk("rst_rd_valid", app_rd_data_valid, 1'b0);
        chk("cal_fail", cal_fail, 1'b0);
        ddr3_rst = 1'b0;
        for (int k = 1; k <= INIT + 4; k++) begin
            @(negedge ddr3_clk);
            chk("init_phy_rdy", phy_rdy, (k >= INIT));
            if (k < INIT) begin
                chk("init_app_rdy", app_rdy, 1'b0);
                chk("init_wdf_rdy", app_wdf_rdy, 1'b0);
            end
        end

        for (int i = 0; i < 16; i++) do_write(32'(i) << 3, rnd288(), rnd288(), '0, '0, 1'b0, 0);

        do_write(32'h10, {36{8'hAA}}, {36{8'h55}}, '0, '0, 1'b0, 0);
        do_read(32'h10);
        do_write(32'h10, rnd288(), rnd288(), 36'h1, '0, 1'b0, 1);
        do_read(32'h10);
        do_read(32'h10);
        do_read(32'h10 + (32'd16 << 3));
        do_read(32'hFFFF_FF17);
        do_write(32'h28, rnd288(), rnd288(), '0, '0, 1'b1, 0);
        do_read(32'h28);
        do_write(32'h30, rnd288(), rnd288(), rmask(), rmask(), 1'b0, 2);
        do_read(32'h30);

        for (int c = 2; c < 8; c++) begin
            issue_cmd(3'(c), 32'h10, acc);
`ifndef DDR3_RESP_BACKPRESSURE_EN
            chk("bad_cmd_frees_rdy", app_rdy, 1'b1);
`endif
        end
        do_read(32'h18);

`ifdef DDR3_RESP_BACKPRESSURE_EN
        n_pairs = 1000;
`else
        n_pairs = 150;
`endif
        for (int i = 0; i < n_pairs; i++) begin
            a = $urandom;
            do_write(a, rnd288(), rnd288(), rmask(), rmask(), ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) a = $urandom;
            do_read(a);
        end

        // Reset during an in-flight read and between write beats.
        do_read(32'h40);
        send_beat(rnd288(), '0, 1'b0);
        sb.delete();
        ddr3_rst = 1'b1;
        #1;
        chk("midrst_phy_rdy", phy_rdy, 1'b0);
        chk("midrst_app_rdy", app_rdy, 1'b0);
        chk("midrst_wdf_rdy", app_wdf_rdy, 1'b0);
        chk("midrst_rd_valid", app_rd_data_valid, 1'b0);
        chk("midrst_rd_end", app_rd_data_end, 1'b0);
        chk("midrst_rd_data", app_rd_data, '0);
        repeat (3) @(negedge ddr3_clk);
        ddr3_rst = 1'b0;
        wait_init();
        for (int i = 0; i < 16; i++) do_read(32'(i) << 3);
        do_write(32'h38, rnd288(), rnd288(), '0, '0, 1'b0, 0);
        do_read(32'h38);

        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge ddr3_clk);
        chk("sb_drained", sb.size(), 0);
`ifdef DDR3_RESP_BACKPRESSURE_EN
        chk("bp_app_rdy_low_seen", (bp_low > 0), 1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
